// File: rtl/key_debounce_quad_pkg.sv
// Shared constants for the quad key debouncer: FSM state encoding and
// default timing values (50 MHz clock).
package key_debounce_quad_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_PRESS_CHK = 2'd1,
    ST_HELD      = 2'd2,
    ST_REL_CHK   = 2'd3
  } key_fsm_e;

  localparam int DEF_DEBOUNCE_CNT  = 1_000_000;   // 20 ms
  localparam int DEF_REPEAT_EN     = 1;
  localparam int DEF_REPEAT_DELAY  = 15_000_000;  // 300 ms
  localparam int DEF_REPEAT_PERIOD = 5_000_000;   // 100 ms

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/key_debounce_ch.sv
// One key channel: 2-flop synchronizer, press/release debounce FSM and
// auto-repeat counter. Emits a one-cycle flag on confirmed press and repeats.
module key_debounce_ch
  import key_debounce_quad_pkg::*;
#(
  parameter int DEBOUNCE_CNT  = DEF_DEBOUNCE_CNT,
  parameter int REPEAT_EN     = DEF_REPEAT_EN,
  parameter int REPEAT_DELAY  = DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD = DEF_REPEAT_PERIOD
) (
  input  logic     clk,
  input  logic     rst_n,
  input  logic     key_n,
  output logic     key_flag,
  output logic     key_state,
  output key_fsm_e state_o
);

  localparam int CW = $clog2(max3(DEBOUNCE_CNT, REPEAT_DELAY, REPEAT_PERIOD)) + 1;
  localparam logic [CW-1:0] DEB_LAST = CW'(DEBOUNCE_CNT - 1);
  localparam logic [CW-1:0] RD_LAST  = CW'(REPEAT_DELAY - 1);
  localparam logic [CW-1:0] RP_LAST  = CW'(REPEAT_PERIOD - 1);

  logic [1:0]    sync_q;
  logic          key_low;
  key_fsm_e      state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] rpt_q, rpt_d;
  logic          rpt_first_q, rpt_first_d;
  logic          flag_q, flag_d;
  logic          held_q, held_d;

  assign key_low = ~sync_q[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q      <= 2'b11;
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      rpt_q       <= '0;
      rpt_first_q <= 1'b0;
      flag_q      <= 1'b0;
      held_q      <= 1'b0;
    end else begin
      sync_q      <= {sync_q[0], key_n};
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rpt_q       <= rpt_d;
      rpt_first_q <= rpt_first_d;
      flag_q      <= flag_d;
      held_q      <= held_d;
    end
  end

  // rpt_first_q selects the long initial delay right after a press; a return
  // from REL_CHK resumes on the short period.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rpt_d       = rpt_q;
    rpt_first_d = rpt_first_q;
    flag_d      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        rpt_d = '0;
        if (key_low) state_d = ST_PRESS_CHK;
      end
      ST_PRESS_CHK: begin
        if (!key_low) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == DEB_LAST) begin
          state_d     = ST_HELD;
          cnt_d       = '0;
          rpt_d       = '0;
          rpt_first_d = 1'b1;
          flag_d      = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_HELD: begin
        if (!key_low) begin
          state_d = ST_REL_CHK;
          cnt_d   = '0;
          rpt_d   = '0;
        end else if (REPEAT_EN != 0) begin
          if (rpt_q == (rpt_first_q ? RD_LAST : RP_LAST)) begin
            flag_d      = 1'b1;
            rpt_d       = '0;
            rpt_first_d = 1'b0;
          end else begin
            rpt_d = rpt_q + 1'b1;
          end
        end
      end
      ST_REL_CHK: begin
        if (key_low) begin
          state_d     = ST_HELD;
          cnt_d       = '0;
          rpt_d       = '0;
          rpt_first_d = 1'b0;
        end else if (cnt_q == DEB_LAST) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
        rpt_d   = '0;
      end
    endcase
    held_d = (state_d == ST_HELD) || (state_d == ST_REL_CHK);
  end

  assign key_flag  = flag_q;
  assign key_state = held_q;
  assign state_o   = state_q;

endmodule

// File: rtl/key_debounce_quad.sv
// Four independent debounced keys. key_fsm_o exposes each channel's FSM
// state, two bits per key, key 0 in the low bits.
module key_debounce_quad
  import key_debounce_quad_pkg::*;
#(
  parameter int DEBOUNCE_CNT  = DEF_DEBOUNCE_CNT,
  parameter int REPEAT_EN     = DEF_REPEAT_EN,
  parameter int REPEAT_DELAY  = DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD = DEF_REPEAT_PERIOD
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] key_n,
  output logic       key_flag1,
  output logic       key_flag2,
  output logic       key_flag3,
  output logic       key_flag4,
  output logic [3:0] key_state,
  output logic [7:0] key_fsm_o
);

  logic [3:0] flag;
  key_fsm_e   ch_fsm [4];

  for (genvar g = 0; g < 4; g++) begin : g_ch
    key_debounce_ch #(
      .DEBOUNCE_CNT (DEBOUNCE_CNT),
      .REPEAT_EN    (REPEAT_EN),
      .REPEAT_DELAY (REPEAT_DELAY),
      .REPEAT_PERIOD(REPEAT_PERIOD)
    ) u_ch (
      .clk      (clk),
      .rst_n    (rst_n),
      .key_n    (key_n[g]),
      .key_flag (flag[g]),
      .key_state(key_state[g]),
      .state_o  (ch_fsm[g])
    );
    assign key_fsm_o[2*g +: 2] = ch_fsm[g];
  end

  assign key_flag1 = flag[0];
  assign key_flag2 = flag[1];
  assign key_flag3 = flag[2];
  assign key_flag4 = flag[3];

endmodule

// File: doc/key_debounce_quad.md
KEY_DEBOUNCE_QUAD -- requirements
Module: key_debounce_quad

Interface
REQ-001 SHALL have parameter DEBOUNCE_CNT, default 1_000_000, meaning the number of consecutive stable clk cycles that confirms a press or release (20 ms at 50 MHz).
REQ-002 SHALL have parameter REPEAT_EN, default 1, meaning 1 enables auto-repeat pulses while a key is held and 0 disables them.
REQ-003 SHALL have parameter REPEAT_DELAY, default 15_000_000, meaning the cycles from the press pulse to the first repeat pulse.
REQ-004 SHALL have parameter REPEAT_PERIOD, default 5_000_000, meaning the cycles between subsequent repeat pulses.
REQ-005 SHALL have port clk, input, 1 bit: system clock; the block uses this single clock domain.
REQ-006 SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-007 SHALL have port key_n, input, 4 bits: raw push-buttons, active-low, asynchronous to clk and bouncing.
REQ-008 SHALL have ports key_flag1, key_flag2, key_flag3 and key_flag4, each an output of 1 bit, each a one-cycle press/repeat pulse for key_n[0], key_n[1], key_n[2] and key_n[3] respectively.
REQ-009 SHALL have port key_state, output, 4 bits: debounced level, where 1 means held (HELD or REL_CHK).

Function
REQ-010 SHALL pass each key_n bit through a 2-flop synchronizer, reset to 1, before any other use.
REQ-011 SHALL run an independent 4-state FSM per key, with states IDLE, PRESS_CHK, HELD and REL_CHK.
REQ-012 IDLE: synchronized key low -> PRESS_CHK with the debounce counter cleared.
REQ-013 PRESS_CHK: counter increments each cycle while the key stays low; key high -> IDLE with the counter cleared; counter reaching DEBOUNCE_CNT-1 with the key low -> HELD.
REQ-014 SHALL assert key_flagN for exactly one cycle, the first cycle in HELD; the flag is therefore high DEBOUNCE_CNT+2 cycles after a clean raw falling edge.
REQ-015 HELD: synchronized key high -> REL_CHK with the counter cleared.
REQ-016 REL_CHK: key high for DEBOUNCE_CNT consecutive cycles -> IDLE; key low before then -> HELD; neither transition emits a flag.
REQ-017 Auto-repeat (REPEAT_EN=1): while in HELD, the repeat counter runs and pulses key_flagN at REPEAT_DELAY cycles after the press pulse, then every REPEAT_PERIOD cycles.
REQ-018 SHALL never pulse key_flagN in REL_CHK; on a return from REL_CHK to HELD, the next repeat pulse comes REPEAT_PERIOD cycles later.
REQ-019 REPEAT_EN=0: SHALL emit exactly one pulse per confirmed press.
REQ-020 Counters SHALL be sized $clog2(max parameter)+1 bits, SHALL never wrap, and SHALL be cleared on every state change.
REQ-021 Keys SHALL be fully independent; simultaneous presses SHALL give simultaneous flags, with no priority and no masking (opposite-key arbitration belongs to the consumer).
REQ-022 key_state[N] SHALL be registered, and equal 1 in HELD and REL_CHK only.

Reset
REQ-023 rst_n low SHALL immediately force all FSMs to IDLE, all counters to 0, synchronizer flops to 1, key_flag1..4 to 0 and key_state to 0.
REQ-024 A key held through reset deassertion SHALL be debounced afresh and pulse DEBOUNCE_CNT+2 cycles after rst_n rises; reset mid-PRESS_CHK SHALL emit no pulse.

Structure
REQ-025 State encodings (2-bit IDLE=0, PRESS_CHK=1, HELD=2, REL_CHK=3) and default timing constants SHALL live in a shared game-constants include.
REQ-026 Per-key logic SHALL be one sub-module, key_debounce_ch, containing synchronizer, FSM and counters, instantiated 4x with a generate loop; the top only maps outputs.

Verification (DEBOUNCE_CNT=8, REPEAT_DELAY=20, REPEAT_PERIOD=5)
REQ-027 Clean press of key_n[0] at cycle 0, held 12 cycles -> key_flag1 high only in cycle 10, key_state[0]=1, other flags 0.
REQ-028 key_n[1] low/high toggling every 3 cycles for 40 cycles, then steady low -> no pulse during toggling, exactly one pulse 10 cycles after steady low.
REQ-029 key_n[2] held 60 cycles with REPEAT_EN=1 -> pulses at cycles 10, 30, 35, 40, 45, 50, 55; with REPEAT_EN=0 -> cycle 10 only.
REQ-030 Held key_n[3] releases with a 4-cycle glitch high, then low again -> no pulse, key_state[3] stays 1, next repeat pulse arrives 5 cycles after the return.
REQ-031 key_n[0] and key_n[1] pressed in the same cycle -> key_flag1 and key_flag2 pulse in the same cycle (cycle 10).
REQ-032 rst_n pulsed low at cycle 5 of a press that stays held -> outputs 0 immediately, one pulse 10 cycles after rst_n rises.
